rl_queue_packer: RTL and testbench

- Upstream width-conversion stage that feeds the team's fall-through queue.
- Accepts a narrow valid/ready beat stream and assembles RATIO beats into one wide word, least-significant beat first.
- Issues the word as a single queue write (we_o/q_o), throttled by the queue's full flag.
- Shortens the word on last_i so packet tails are never stranded in the assembly register.

---
 rtl/rl_packer_pkg.sv | 18 +
 rtl/rl_queue_packer_if.sv | 40 ++++
 rtl/rl_packer_lane_mux.sv | 40 ++++
 rtl/rl_queue_packer.sv | 101 ++++++++++
 tb/tb_rl_queue_packer.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rl_packer_pkg.sv
// Shared definitions for the rl_queue_packer width-conversion stage.
// Optional lane-mask output is enabled with the RL_PACKER_MASK_EN macro.
package rl_packer_pkg;

  // Output word width: RATIO beats of IBITS each.
  function automatic int obits(input int ibits, input int ratio);
    return ibits * ratio;
  endfunction

  // Beat counter width: clog2(RATIO), never narrower than one bit.
  function automatic int cnt_bits(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // Lane index wide enough for any practical RATIO; used for lane compares.
  typedef logic [15:0] lane_idx_t;

endpackage

// File: rtl/rl_queue_packer_if.sv
// Bundles the narrow beat stream and the queue write port of rl_queue_packer.
// Carries be_o when RL_PACKER_MASK_EN is defined.
//
// Handshake: a beat moves when dv_i and rdy_o are both high at a rising edge.
// dv_i/d_i/last_i stay stable until that edge; rdy_o never depends on dv_i.
// On the queue side a word is written in every cycle where we_o is high;
// we_o is already gated by full_i, so the queue simply obeys we_o.
interface rl_queue_packer_if
  import rl_packer_pkg::*;
#(
  parameter int IBITS = 8,
  parameter int RATIO = 4
) ();

  localparam int OBITS = obits(IBITS, RATIO);
  localparam int CW    = cnt_bits(RATIO);

  logic [IBITS-1:0] d_i;
  logic             dv_i;
  logic             last_i;
  logic             rdy_o;
  logic             full_i;
  logic             we_o;
  logic [OBITS-1:0] q_o;
  logic [CW-1:0]    cnt_o;
`ifdef RL_PACKER_MASK_EN
  logic [RATIO-1:0] be_o;

  modport slave  (input d_i, dv_i, last_i, full_i,
                  output rdy_o, we_o, q_o, cnt_o, be_o);
  modport master (output d_i, dv_i, last_i, full_i,
                  input rdy_o, we_o, q_o, cnt_o, be_o);
`else
  modport slave  (input d_i, dv_i, last_i, full_i,
                  output rdy_o, we_o, q_o, cnt_o);
  modport master (output d_i, dv_i, last_i, full_i,
                  input rdy_o, we_o, q_o, cnt_o);
`endif

endinterface

// File: rtl/rl_packer_lane_mux.sv
// Combinational merge of one beat into lane 'lane' of the assembly word.
// Lanes below 'lane' come from the assembly word, lanes above are zeroed.
// With RL_PACKER_MASK_EN it also produces the matching lane-valid mask.
module rl_packer_lane_mux
  import rl_packer_pkg::*;
#(
  parameter int IBITS = 8,
  parameter int RATIO = 4
) (
  input  logic [IBITS*RATIO-1:0]     asm_word,
  input  logic [IBITS-1:0]           beat,
  input  logic [cnt_bits(RATIO)-1:0] lane,
`ifdef RL_PACKER_MASK_EN
  output logic [RATIO-1:0]           mask,
`endif
  output logic [IBITS*RATIO-1:0]     merged
);

  // Select per lane: held beat, incoming beat, or zero fill.
  always_comb begin
    merged = '0;
`ifdef RL_PACKER_MASK_EN
    mask = '0;
`endif
    for (int i = 0; i < RATIO; i++) begin
      if (lane_idx_t'(i) < lane_idx_t'(lane)) begin
        merged[i*IBITS +: IBITS] = asm_word[i*IBITS +: IBITS];
`ifdef RL_PACKER_MASK_EN
        mask[i] = 1'b1;
`endif
      end else if (lane_idx_t'(i) == lane_idx_t'(lane)) begin
        merged[i*IBITS +: IBITS] = beat;
`ifdef RL_PACKER_MASK_EN
        mask[i] = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/rl_queue_packer.sv
// Packs RATIO narrow beats (LSB beat first) into one wide queue write.
// last_i closes a word early with zero-filled upper lanes.
// RL_PACKER_MASK_EN adds the registered lane-valid output be_o.
module rl_queue_packer
  import rl_packer_pkg::*;
#(
  parameter int IBITS = 8,
  parameter int RATIO = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           ena_i,
  rl_queue_packer_if.slave bus
);

  localparam int OBITS = obits(IBITS, RATIO);
  localparam int CW    = cnt_bits(RATIO);

  logic [OBITS-1:0] asm_q;
  logic [OBITS-1:0] out_q;
  logic [OBITS-1:0] merged;
  logic [CW-1:0]    cnt_q;
  logic             pend_q;
  logic             rdy;
  logic             we;
  logic             acc;
  logic             complete;
`ifdef RL_PACKER_MASK_EN
  logic [RATIO-1:0] be_q;
  logic [RATIO-1:0] mask;
`endif

  // Ready when the out slot is empty or is being drained this cycle.
  assign rdy      = ena_i & (~pend_q | ~bus.full_i);
  assign we       = ena_i & pend_q & ~bus.full_i;
  assign acc      = bus.dv_i & rdy;
  assign complete = acc & ((cnt_q == CW'(RATIO - 1)) | bus.last_i);

  rl_packer_lane_mux #(
    .IBITS (IBITS),
    .RATIO (RATIO)
  ) u_lane_mux (
    .asm_word (asm_q),
    .beat     (bus.d_i),
    .lane     (cnt_q),
`ifdef RL_PACKER_MASK_EN
    .mask     (mask),
`endif
    .merged   (merged)
  );

  // Assembly, output slot and pending flag; a completing beat reloads the
  // slot in the same cycle it drains, so pend stays set with no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_q  <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
`ifdef RL_PACKER_MASK_EN
      be_q   <= '0;
`endif
    end else if (clr_i) begin
      asm_q  <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
`ifdef RL_PACKER_MASK_EN
      be_q   <= '0;
`endif
    end else if (ena_i) begin
      if (complete) begin
        out_q  <= merged;
        pend_q <= 1'b1;
        asm_q  <= '0;
        cnt_q  <= '0;
`ifdef RL_PACKER_MASK_EN
        be_q   <= mask;
`endif
      end else begin
        if (acc) begin
          asm_q <= merged;
          cnt_q <= cnt_q + CW'(1);
        end
        if (we) begin
          pend_q <= 1'b0;
        end
      end
    end
  end

  assign bus.rdy_o = rdy;
  assign bus.we_o  = we;
  assign bus.q_o   = out_q;
  assign bus.cnt_o = cnt_q;
`ifdef RL_PACKER_MASK_EN
  assign bus.be_o  = be_q;
`endif

endmodule

// File: tb/tb_rl_queue_packer.sv
// Directed self-checking bench for rl_queue_packer (IBITS=8, RATIO=4).
// Checks be_o as well when built with RL_PACKER_MASK_EN.
module tb_rl_queue_packer;

  localparam int IBITS = 8;
  localparam int RATIO = 4;
  localparam int OBITS = 32;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  logic ena   = 1'b0;
  always #5 clk = ~clk;

  rl_queue_packer_if #(.IBITS(IBITS), .RATIO(RATIO)) bus ();

  rl_queue_packer #(.IBITS(IBITS), .RATIO(RATIO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .ena_i  (ena),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // scoreboard: expected words and observed queue writes
  logic [OBITS-1:0] exp_q[$];
  logic [OBITS-1:0] wr_q[$];
  int               wr_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.we_o === 1'b1) begin
      wr_q.push_back(bus.q_o);
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    wr_q.delete();
    wr_cyc.delete();
  endtask

  // Offers one beat and returns once it has been accepted (or gives up).
  task automatic drive_beat(input logic [7:0] d, input logic l, output bit ok);
    ok = 1'b0;
    bus.d_i    = d;
    bus.last_i = l;
    bus.dv_i   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.rdy_o === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) #1;
    bus.dv_i   = 1'b0;
    bus.last_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b0;
    tick(2);
    checks++; if (bus.we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.we_o); end
    checks++; if (bus.q_o !== 32'h0) begin errors++; $display("FAIL reset_q got %h exp 00000000", bus.q_o); end
    checks++; if (bus.cnt_o !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.cnt_o); end
    checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", bus.rdy_o); end
`ifdef RL_PACKER_MASK_EN
    checks++; if (bus.be_o !== 4'b0000) begin errors++; $display("FAIL reset_be got %b exp 0000", bus.be_o); end
`endif
    rst_n = 1'b1;
    ena = 1'b1;
    tick(1);
  endtask

  task automatic test_full_word();
    bit ok;
    bit all_ok = 1'b1;
    logic [7:0] beats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs();
    exp_q.push_back(32'h44332211);
    foreach (beats[i]) begin
      drive_beat(beats[i], 1'b0, ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL full_accept got %b exp 1", all_ok); end
    checks++; if (bus.we_o !== 1'b1) begin errors++; $display("FAIL full_we got %b exp 1", bus.we_o); end
    checks++; if (bus.q_o !== 32'h44332211) begin errors++; $display("FAIL full_q got %h exp 44332211", bus.q_o); end
    checks++; if (bus.cnt_o !== 2'd0) begin errors++; $display("FAIL full_cnt got %0d exp 0", bus.cnt_o); end
`ifdef RL_PACKER_MASK_EN
    checks++; if (bus.be_o !== 4'b1111) begin errors++; $display("FAIL full_be got %b exp 1111", bus.be_o); end
`endif
    tick(1);
    checks++; if (bus.we_o !== 1'b0) begin errors++; $display("FAIL full_we_drop got %b exp 0", bus.we_o); end
    tick(1);
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL full_nwrites got %0d exp %0d", wr_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_wr%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_short_word();
    bit ok1, ok2;
    clear_logs();
    exp_q.push_back(32'h0000BBAA);
    drive_beat(8'hAA, 1'b0, ok1);
    drive_beat(8'hBB, 1'b1, ok2);
    checks++; if ((ok1 & ok2) !== 1'b1) begin errors++; $display("FAIL short_accept got %b exp 1", ok1 & ok2); end
    checks++; if (bus.we_o !== 1'b1) begin errors++; $display("FAIL short_we got %b exp 1", bus.we_o); end
    checks++; if (bus.q_o !== 32'h0000BBAA) begin errors++; $display("FAIL short_q got %h exp 0000bbaa", bus.q_o); end
    checks++; if (bus.cnt_o !== 2'd0) begin errors++; $display("FAIL short_cnt got %0d exp 0", bus.cnt_o); end
`ifdef RL_PACKER_MASK_EN
    checks++; if (bus.be_o !== 4'b0011) begin errors++; $display("FAIL short_be got %b exp 0011", bus.be_o); end
`endif
    tick(2);
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL short_nwrites got %0d exp %0d", wr_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_wr%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  // A full word parks in the out slot under full_i; a 1-beat word then
  // completes in the very cycle the parked word drains.
  task automatic test_backpressure();
    bit ok;
    bit all_ok = 1'b1;
    logic [7:0] beats [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    clear_logs();
    exp_q.push_back(32'hA3A2A1A0);
    exp_q.push_back(32'h0000005A);
    bus.full_i = 1'b1;
    foreach (beats[i]) begin
      drive_beat(beats[i], 1'b0, ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", all_ok); end
    bus.d_i = 8'h5A;
    bus.last_i = 1'b1;
    bus.dv_i = 1'b1;
    repeat (3) begin
      #1;
      checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL bp_rdy_stall got %b exp 0", bus.rdy_o); end
      checks++; if (bus.we_o !== 1'b0) begin errors++; $display("FAIL bp_we_stall got %b exp 0", bus.we_o); end
      @(posedge clk);
      #1;
    end
    checks++; if (bus.q_o !== 32'hA3A2A1A0) begin errors++; $display("FAIL bp_q_held got %h exp a3a2a1a0", bus.q_o); end
    bus.full_i = 1'b0;
    #1;
    checks++; if (bus.we_o !== 1'b1) begin errors++; $display("FAIL bp_we_release got %b exp 1", bus.we_o); end
    checks++; if (bus.rdy_o !== 1'b1) begin errors++; $display("FAIL bp_rdy_release got %b exp 1", bus.rdy_o); end
    @(posedge clk);
    #1;
    bus.dv_i = 1'b0;
    bus.last_i = 1'b0;
    checks++; if (bus.we_o !== 1'b1) begin errors++; $display("FAIL bp_we_second got %b exp 1", bus.we_o); end
    checks++; if (bus.q_o !== 32'h0000005A) begin errors++; $display("FAIL bp_q_second got %h exp 0000005a", bus.q_o); end
`ifdef RL_PACKER_MASK_EN
    checks++; if (bus.be_o !== 4'b0001) begin errors++; $display("FAIL bp_be got %b exp 0001", bus.be_o); end
`endif
    tick(1);
    checks++; if (bus.we_o !== 1'b0) begin errors++; $display("FAIL bp_we_idle got %b exp 0", bus.we_o); end
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_nwrites got %0d exp %0d", wr_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_wr%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
      end
      checks++; if (wr_cyc[1] - wr_cyc[0] !== 1) begin errors++; $display("FAIL bp_gap got %0d exp 1", wr_cyc[1] - wr_cyc[0]); end
    end
  endtask

  task automatic test_back_to_back();
    bit dropped = 1'b0;
    clear_logs();
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    bus.full_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.d_i = 8'(i + 1);
      bus.last_i = 1'b0;
      bus.dv_i = 1'b1;
      #1;
      if (bus.rdy_o !== 1'b1) dropped = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.dv_i = 1'b0;
    tick(2);
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL b2b_rdy_drop got %b exp 0", dropped); end
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_nwrites got %0d exp %0d", wr_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_wr%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
      end
      checks++; if (wr_cyc[1] - wr_cyc[0] !== 4) begin errors++; $display("FAIL b2b_spacing got %0d exp 4", wr_cyc[1] - wr_cyc[0]); end
    end
  endtask

  task automatic test_clear();
    bit ok;
    bit all_ok = 1'b1;
    logic [7:0] park [4]  = '{8'h3C, 8'h2D, 8'h1E, 8'h0F};
    logic [7:0] clean [4] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    clear_logs();
    exp_q.push_back(32'hD4D3D2D1);
    bus.full_i = 1'b1;
    foreach (park[i]) begin
      drive_beat(park[i], 1'b0, ok);
      if (!ok) all_ok = 1'b0;
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    bus.full_i = 1'b0;
    #1;
    checks++; if (bus.we_o !== 1'b0) begin errors++; $display("FAIL clr_we got %b exp 0", bus.we_o); end
    checks++; if (bus.q_o !== 32'h0) begin errors++; $display("FAIL clr_q got %h exp 00000000", bus.q_o); end
`ifdef RL_PACKER_MASK_EN
    checks++; if (bus.be_o !== 4'b0000) begin errors++; $display("FAIL clr_be got %b exp 0000", bus.be_o); end
`endif
    drive_beat(8'h77, 1'b0, ok);
    if (!ok) all_ok = 1'b0;
    drive_beat(8'h66, 1'b0, ok);
    if (!ok) all_ok = 1'b0;
    checks++; if (bus.cnt_o !== 2'd2) begin errors++; $display("FAIL clr_cnt_pre got %0d exp 2", bus.cnt_o); end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    #1;
    checks++; if (bus.cnt_o !== 2'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", bus.cnt_o); end
    foreach (clean[i]) begin
      drive_beat(clean[i], 1'b0, ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++; if (bus.q_o !== 32'hD4D3D2D1) begin errors++; $display("FAIL clr_clean_q got %h exp d4d3d2d1", bus.q_o); end
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL clr_accept got %b exp 1", all_ok); end
    tick(2);
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL clr_nwrites got %0d exp %0d", wr_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL clr_wr%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bit all_ok = 1'b1;
    logic [7:0] park [4]  = '{8'h88, 8'h77, 8'h66, 8'h55};
    logic [7:0] clean [4] = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    clear_logs();
    exp_q.push_back(32'hE4E3E2E1);
    bus.full_i = 1'b1;
    foreach (park[i]) begin
      drive_beat(park[i], 1'b0, ok);
      if (!ok) all_ok = 1'b0;
    end
    bus.full_i = 1'b0;
    #1;
    checks++; if (bus.we_o !== 1'b1) begin errors++; $display("FAIL arst_we_pre got %b exp 1", bus.we_o); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.we_o !== 1'b0) begin errors++; $display("FAIL arst_we got %b exp 0", bus.we_o); end
    checks++; if (bus.q_o !== 32'h0) begin errors++; $display("FAIL arst_q got %h exp 00000000", bus.q_o); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    drive_beat(8'h12, 1'b0, ok);
    if (!ok) all_ok = 1'b0;
    drive_beat(8'h34, 1'b0, ok);
    if (!ok) all_ok = 1'b0;
    checks++; if (bus.cnt_o !== 2'd2) begin errors++; $display("FAIL arst_cnt_pre got %0d exp 2", bus.cnt_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.cnt_o !== 2'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", bus.cnt_o); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    foreach (clean[i]) begin
      drive_beat(clean[i], 1'b0, ok);
      if (!ok) all_ok = 1'b0;
    end
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL arst_accept got %b exp 1", all_ok); end
    tick(2);
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL arst_nwrites got %0d exp %0d", wr_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL arst_wr%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_ena_gap();
    bit ok;
    bit all_ok = 1'b1;
    clear_logs();
    exp_q.push_back(32'h40302010);
    bus.full_i = 1'b0;
    drive_beat(8'h10, 1'b0, ok);
    if (!ok) all_ok = 1'b0;
    drive_beat(8'h20, 1'b0, ok);
    if (!ok) all_ok = 1'b0;
    ena = 1'b0;
    bus.d_i = 8'h30;
    bus.dv_i = 1'b1;
    repeat (3) begin
      #1;
      checks++; if (bus.rdy_o !== 1'b0) begin errors++; $display("FAIL ena_rdy got %b exp 0", bus.rdy_o); end
      checks++; if (bus.cnt_o !== 2'd2) begin errors++; $display("FAIL ena_cnt_hold got %0d exp 2", bus.cnt_o); end
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
    bus.dv_i = 1'b0;
    drive_beat(8'h30, 1'b0, ok);
    if (!ok) all_ok = 1'b0;
    drive_beat(8'h40, 1'b0, ok);
    if (!ok) all_ok = 1'b0;
    ena = 1'b0;
    #1;
    checks++; if (bus.we_o !== 1'b0) begin errors++; $display("FAIL ena_we_gated got %b exp 0", bus.we_o); end
    tick(2);
    checks++; if (bus.we_o !== 1'b0) begin errors++; $display("FAIL ena_we_gated2 got %b exp 0", bus.we_o); end
    checks++; if (bus.q_o !== 32'h40302010) begin errors++; $display("FAIL ena_q_held got %h exp 40302010", bus.q_o); end
    ena = 1'b1;
    #1;
    checks++; if (bus.we_o !== 1'b1) begin errors++; $display("FAIL ena_we_resume got %b exp 1", bus.we_o); end
    tick(2);
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL ena_accept got %b exp 1", all_ok); end
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL ena_nwrites got %0d exp %0d", wr_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL ena_wr%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    bus.d_i    = '0;
    bus.dv_i   = 1'b0;
    bus.last_i = 1'b0;
    bus.full_i = 1'b0;
    test_reset();
    test_full_word();
    test_short_word();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_ena_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
